// File: rtl/mul_add_pkg.sv
// Shared types and constants for the multiply-add (Q*D+R) block.
package mul_add_pkg;

  // Default operand width.
  localparam int MUL_ADD_WIDTH = 8;

  // One shift-add iteration per multiplier bit.
  function automatic int iter_count(input int width);
    return width;
  endfunction

  // Iteration count for the default width.
  localparam int MUL_ADD_ITERS = iter_count(MUL_ADD_WIDTH);

  // FSM state encoding kept as plain constants for legacy compatibility.
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t CALC = 2'd1;
  localparam state_t DONE = 2'd2;

endpackage

// File: rtl/mul_add_cir_if.sv
// Request/result bundle for mul_add_cir: operands and start in, result and status out.
interface mul_add_cir_if
  import mul_add_pkg::*;
#(
  parameter int WIDTH = MUL_ADD_WIDTH
);

  logic               ready;
  logic [WIDTH-1:0]   Quotient;
  logic [WIDTH-1:0]   Divisor;
  logic [WIDTH-1:0]   Reminder;
  logic [2*WIDTH-1:0] Dividend;
  logic               busy;
  logic               done;
  logic               rem_err;

  // Requester side: issues operands and start, observes result.
  modport master (
    output ready, Quotient, Divisor, Reminder,
    input  Dividend, busy, done, rem_err
  );

  // Calculator side.
  modport slave (
    input  ready, Quotient, Divisor, Reminder,
    output Dividend, busy, done, rem_err
  );

endinterface

// File: rtl/mul_add_cir.sv
// Sequential shift-add multiply-accumulate: Dividend = Quotient*Divisor + Reminder.
// Fixed latency of WIDTH iterations; rem_err flags Reminder >= Divisor at capture.
module mul_add_cir
  import mul_add_pkg::*;
#(
  parameter int WIDTH = MUL_ADD_WIDTH
) (
  input logic          clk,
  input logic          rst_n,
  mul_add_cir_if.slave bus
);

  localparam int             ITERS = iter_count(WIDTH);
  localparam int             CW    = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST  = CW'(ITERS - 1);

  state_t             state;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               rem_ge;

  logic [2*WIDTH-1:0] dividend_q;
  logic               busy_q;
  logic               done_q;
  logic               rem_err_q;

  logic [2*WIDTH-1:0] sum;
  logic               last_iter;

  // Next accumulator value for the current iteration and last-iteration detect.
  always_comb begin
    sum       = acc + (mplier[0] ? mcand : '0);
    last_iter = (cnt == LAST);
  end

  // Control FSM and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rem_err_q  <= 1'b0;
      dividend_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ready) begin
            busy_q <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          if (last_iter) begin
            dividend_q <= sum;
            done_q     <= 1'b1;
            rem_err_q  <= rem_ge;
            state      <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Operand capture and shift-add datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      rem_ge <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ready) begin
            acc    <= {{WIDTH{1'b0}}, bus.Reminder};
            mcand  <= {{WIDTH{1'b0}}, bus.Divisor};
            mplier <= bus.Quotient;
            cnt    <= '0;
            rem_ge <= (bus.Reminder >= bus.Divisor);
          end
        end
        CALC: begin
          acc    <= sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Drive the result bundle from registered state.
  always_comb begin
    bus.Dividend = dividend_q;
    bus.busy     = busy_q;
    bus.done     = done_q;
    bus.rem_err  = rem_err_q;
  end

endmodule
